// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard unit.
// FSM states, forwarding selects and the stall/flush bundle.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    TIMEOUT = 2'b10
  } hz_state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic flush_id;
    logic flush_ex;
  } hz_ctl_t;

  localparam hz_ctl_t CTL_NONE  = hz_ctl_t'(6'b000000);
  localparam hz_ctl_t CTL_HOLD  = hz_ctl_t'(6'b111100);
  localparam hz_ctl_t CTL_REDIR = hz_ctl_t'(6'b000011);
  localparam hz_ctl_t CTL_LDUSE = hz_ctl_t'(6'b110001);

  // r0 is hardwired zero: it never produces a hit.
  function automatic logic reg_hit(
    input logic [4:0] dst,
    input logic       en,
    input logic [4:0] src
  );
    return en && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/pipe_fwdunit.sv
// EX operand forwarding select for one source register.
// MEM result wins over WB result; register 0 never forwards.
module pipe_fwdunit
  import pipe_pkg::*;
(
  input  logic [4:0] ex_src,
  input  logic [4:0] mem_writereg,
  input  logic       mem_regwriteen,
  input  logic [4:0] wb_writereg,
  input  logic       wb_regwriteen,
  output logic [1:0] fwd
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = reg_hit(mem_writereg, mem_regwriteen, ex_src);
  assign wb_hit  = reg_hit(wb_writereg, wb_regwriteen, ex_src);

  always_comb begin
    fwd = FWD_REG;
    if (mem_hit) begin
      fwd = FWD_MEM;
    end else if (wb_hit) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard.sv
// Pipeline hazard unit: stalls, flushes, forwarding, memory-wait timeout.
// Define PIPE_HAZARD_PERF_EN to add stall_cnt/flush_cnt counters.
module pipe_hazard
  import pipe_pkg::*;
#(
  parameter int MEMWAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_writereg,
  input  logic        ex_memtoreg,
  input  logic        ex_regwriteen,
  input  logic        ex_branchtaken,
  input  logic        ex_jump,
  input  logic [4:0]  mem_writereg,
  input  logic        mem_regwriteen,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic [4:0]  wb_writereg,
  input  logic        wb_regwriteen,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        stall_mem,
  output logic        flush_id,
  output logic        flush_ex,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic        hz_err
);

  localparam logic [8:0] WAIT_LIMIT = 9'(MEMWAIT_MAX);

  hz_state_t  state;
  hz_state_t  state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic [8:0] cnt_inc;
  logic       err_q;

  logic       mem_wait;
  logic       redirect;
  logic       load_use;
  hz_ctl_t    run_ctl;
  hz_ctl_t    ctl;

  assign mem_wait = mem_req & ~mem_ready;
  assign redirect = ex_branchtaken | ex_jump;
  assign load_use = ex_memtoreg &
                    (reg_hit(ex_writereg, ex_regwriteen, id_rs) |
                     reg_hit(ex_writereg, ex_regwriteen, id_rt));
  assign cnt_inc  = {1'b0, cnt} + 9'd1;

  // Outputs the pipeline gets whenever it is free to run.
  always_comb begin
    run_ctl = CTL_NONE;
    if (mem_wait) begin
      run_ctl = CTL_HOLD;
    end else if (redirect) begin
      run_ctl = CTL_REDIR;
    end else if (load_use) begin
      run_ctl = CTL_LDUSE;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ctl       = CTL_NONE;
    unique case (state)
      RUN: begin
        ctl = run_ctl;
        if (mem_wait) begin
          state_nxt = MEMWAIT;
          cnt_nxt   = 8'd1;
        end
      end
      MEMWAIT: begin
        if (mem_ready) begin
          ctl       = run_ctl;
          state_nxt = RUN;
          cnt_nxt   = 8'd0;
        end else begin
          ctl     = CTL_HOLD;
          cnt_nxt = cnt_inc[7:0];
          if (cnt_inc >= WAIT_LIMIT) begin
            state_nxt = TIMEOUT;
          end
        end
      end
      TIMEOUT: begin
        ctl = CTL_HOLD;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= 8'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err_q <= err_q | (state_nxt == TIMEOUT);
    end
  end

  assign stall_if  = ctl.stall_if;
  assign stall_id  = ctl.stall_id;
  assign stall_ex  = ctl.stall_ex;
  assign stall_mem = ctl.stall_mem;
  assign flush_id  = ctl.flush_id;
  assign flush_ex  = ctl.flush_ex;
  assign hz_err    = err_q;

  pipe_fwdunit u_fwd_a (
    .ex_src         (ex_rs),
    .mem_writereg   (mem_writereg),
    .mem_regwriteen (mem_regwriteen),
    .wb_writereg    (wb_writereg),
    .wb_regwriteen  (wb_regwriteen),
    .fwd            (fwd_a)
  );

  pipe_fwdunit u_fwd_b (
    .ex_src         (ex_rt),
    .mem_writereg   (mem_writereg),
    .mem_regwriteen (mem_regwriteen),
    .wb_writereg    (wb_writereg),
    .wb_regwriteen  (wb_regwriteen),
    .fwd            (fwd_b)
  );

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      stall_cnt <= stall_cnt + 32'(ctl.stall_if);
      flush_cnt <= flush_cnt + 32'(ctl.flush_ex);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard.sv
// Directed testbench for pipe_hazard (MEMWAIT_MAX = 4).
// ctl packs {stall_if,stall_id,stall_ex,stall_mem,flush_id,flush_ex}.
module tb_pipe_hazard;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs, id_rt;
  logic [4:0]  ex_rs, ex_rt, ex_writereg;
  logic        ex_memtoreg, ex_regwriteen;
  logic        ex_branchtaken, ex_jump;
  logic [4:0]  mem_writereg;
  logic        mem_regwriteen, mem_req, mem_ready;
  logic [4:0]  wb_writereg;
  logic        wb_regwriteen;
  logic        stall_if, stall_id, stall_ex, stall_mem;
  logic        flush_id, flush_ex;
  logic [1:0]  fwd_a, fwd_b;
  logic        hz_err;
  logic [31:0] stall_cnt, flush_cnt;
  logic [5:0]  ctl;

  int checks = 0;
  int errors = 0;

  assign ctl = {stall_if, stall_id, stall_ex,
                stall_mem, flush_id, flush_ex};

  pipe_hazard #(.MEMWAIT_MAX(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .ex_writereg    (ex_writereg),
    .ex_memtoreg    (ex_memtoreg),
    .ex_regwriteen  (ex_regwriteen),
    .ex_branchtaken (ex_branchtaken),
    .ex_jump        (ex_jump),
    .mem_writereg   (mem_writereg),
    .mem_regwriteen (mem_regwriteen),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .wb_writereg    (wb_writereg),
    .wb_regwriteen  (wb_regwriteen),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .stall_ex       (stall_ex),
    .stall_mem      (stall_mem),
    .flush_id       (flush_id),
    .flush_ex       (flush_ex),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
`ifdef PIPE_HAZARD_PERF_EN
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
`endif
    .hz_err         (hz_err)
  );

`ifndef PIPE_HAZARD_PERF_EN
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    id_rs = 0; id_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_writereg = 0;
    ex_memtoreg = 0; ex_regwriteen = 0;
    ex_branchtaken = 0; ex_jump = 0;
    mem_writereg = 0; mem_regwriteen = 0;
    mem_req = 0; mem_ready = 0;
    wb_writereg = 0; wb_regwriteen = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    @(negedge clk);
    @(negedge clk);
    #2;
    checks++;
    if (ctl !== 6'b000000) begin
      errors++;
      $display("FAIL reset_ctl got %b want 000000", ctl);
    end
    checks++;
    if (hz_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got %b want 0", hz_err);
    end
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_fwd got %b want 0000", {fwd_a, fwd_b});
    end
    release_reset();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    idle();
    ex_memtoreg = 1; ex_regwriteen = 1;
    ex_writereg = 5; id_rt = 5;
    #2;
    checks++;
    if (ctl !== 6'b110001) begin
      errors++;
      $display("FAIL lduse_rt got %b want 110001", ctl);
    end
    @(negedge clk);
    ex_writereg = 0; id_rt = 0;
    #2;
    checks++;
    if (ctl !== 6'b000000) begin
      errors++;
      $display("FAIL lduse_r0 got %b want 000000", ctl);
    end
    @(negedge clk);
    ex_writereg = 7; id_rs = 7;
    #2;
    checks++;
    if (ctl !== 6'b110001) begin
      errors++;
      $display("FAIL lduse_rs got %b want 110001", ctl);
    end
    @(negedge clk);
    ex_memtoreg = 0;
    #2;
    checks++;
    if (ctl !== 6'b000000) begin
      errors++;
      $display("FAIL lduse_noload got %b want 000000", ctl);
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    idle();
    ex_memtoreg = 1; ex_regwriteen = 1;
    ex_writereg = 5; id_rt = 5;
    ex_branchtaken = 1;
    #2;
    checks++;
    if (ctl !== 6'b000011) begin
      errors++;
      $display("FAIL br_over_lduse got %b want 000011", ctl);
    end
    @(negedge clk);
    idle();
    ex_jump = 1;
    #2;
    checks++;
    if (ctl !== 6'b000011) begin
      errors++;
      $display("FAIL jump got %b want 000011", ctl);
    end
  endtask

  task automatic test_memwait();
    @(negedge clk);
    idle();
    mem_req = 1; mem_ready = 0;
    ex_branchtaken = 1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #2;
      checks++;
      if (ctl !== 6'b111100) begin
        errors++;
        $display("FAIL wait_c%0d got %b want 111100", i, ctl);
      end
    end
    @(negedge clk);
    mem_ready = 1;
    #2;
    checks++;
    if (ctl !== 6'b000011) begin
      errors++;
      $display("FAIL wait_exit got %b want 000011", ctl);
    end
    @(negedge clk);
    idle();
    #2;
    checks++;
    if (ctl !== 6'b000000 || hz_err !== 1'b0) begin
      errors++;
      $display("FAIL wait_after got %b/%b want 000000/0",
               ctl, hz_err);
    end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    idle();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #2;
      checks++;
      if (ctl !== 6'b111100 || hz_err !== 1'b0) begin
        errors++;
        $display("FAIL to_wait%0d got %b/%b want 111100/0",
                 i, ctl, hz_err);
      end
    end
    @(negedge clk);
    #2;
    checks++;
    if (ctl !== 6'b111100 || hz_err !== 1'b1) begin
      errors++;
      $display("FAIL to_enter got %b/%b want 111100/1",
               ctl, hz_err);
    end
    @(negedge clk);
    mem_ready = 1; ex_branchtaken = 1;
    #2;
    checks++;
    if (ctl !== 6'b111100 || hz_err !== 1'b1) begin
      errors++;
      $display("FAIL to_hold got %b/%b want 111100/1",
               ctl, hz_err);
    end
    @(negedge clk);
    idle();
    #2;
    checks++;
    if (ctl !== 6'b111100) begin
      errors++;
      $display("FAIL to_idle got %b want 111100", ctl);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (ctl !== 6'b000000 || hz_err !== 1'b0) begin
      errors++;
      $display("FAIL to_reset got %b/%b want 000000/0",
               ctl, hz_err);
    end
    release_reset();
  endtask

  task automatic test_reset_memwait();
    @(negedge clk);
    idle();
    mem_req = 1; mem_ready = 0;
    @(negedge clk);
    mem_req = 0;
    #2;
    checks++;
    if (ctl !== 6'b111100) begin
      errors++;
      $display("FAIL mw_held got %b want 111100", ctl);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (ctl !== 6'b000000) begin
      errors++;
      $display("FAIL mw_reset got %b want 000000", ctl);
    end
    release_reset();
  endtask

  task automatic test_fwd();
    @(negedge clk);
    idle();
    mem_writereg = 8; wb_writereg = 8; ex_rs = 8;
    mem_regwriteen = 1; wb_regwriteen = 1;
    #2;
    checks++;
    if (fwd_a !== 2'b10) begin
      errors++;
      $display("FAIL fwd_a_mem got %b want 10", fwd_a);
    end
    mem_regwriteen = 0;
    #1;
    checks++;
    if (fwd_a !== 2'b01) begin
      errors++;
      $display("FAIL fwd_a_wb got %b want 01", fwd_a);
    end
    wb_regwriteen = 0;
    #1;
    checks++;
    if (fwd_a !== 2'b00) begin
      errors++;
      $display("FAIL fwd_a_none got %b want 00", fwd_a);
    end
    @(negedge clk);
    idle();
    mem_writereg = 0; ex_rs = 0; ex_rt = 0;
    mem_regwriteen = 1; wb_regwriteen = 1;
    #2;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      errors++;
      $display("FAIL fwd_r0 got %b want 0000", {fwd_a, fwd_b});
    end
    @(negedge clk);
    idle();
    ex_rt = 9; ex_rs = 3;
    wb_writereg = 9; wb_regwriteen = 1;
    mem_writereg = 3; mem_regwriteen = 1;
    #2;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b1001) begin
      errors++;
      $display("FAIL fwd_ab got %b want 1001", {fwd_a, fwd_b});
    end
    mem_writereg = 9;
    #1;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0010) begin
      errors++;
      $display("FAIL fwd_b_mem got %b want 0010", {fwd_a, fwd_b});
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_memwait();
    test_timeout();
    test_reset_memwait();
    test_fwd();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
